// File: rtl/pipe_sync_pkg.sv
//------------------------------------------------------------------------------
// Module  : bnn_pkg
// Brief   : Shared constants for the BNN front-end input synchroniser.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bnn_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int SYNC_STAGES_MIN     = 2;
  localparam int SYNC_STAGES_MAX     = 4;

  // Channel slots inside the synchroniser bank
  localparam int CH_P   = 0;
  localparam int CH_W   = 1;
  localparam int CH_EN  = 2;
  localparam int NUM_CH = 3;

  function automatic bit sync_depth_legal(input int depth);
    return (depth >= SYNC_STAGES_MIN) && (depth <= SYNC_STAGES_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_sync_if.sv
//------------------------------------------------------------------------------
// Module  : pipe_sync_if
// Brief   : Pad-side asynchronous inputs and core-side synchronised outputs.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pipe_sync_if;

  logic async_in_p;
  logic async_in_w;
  logic async_in_en;
  logic sync_out_p;
  logic sync_out_w;
  logic sync_out_en;

  // master: pad / loader side, slave: the synchroniser itself
  modport master (
    output async_in_p,
    output async_in_w,
    output async_in_en,
    input  sync_out_p,
    input  sync_out_w,
    input  sync_out_en
  );

  modport slave (
    input  async_in_p,
    input  async_in_w,
    input  async_in_en,
    output sync_out_p,
    output sync_out_w,
    output sync_out_en
  );

endinterface

`default_nettype wire

// File: rtl/pipe_sync_sync_bit.sv
//------------------------------------------------------------------------------
// Module  : sync_bit
// Brief   : SYNC_STAGES-deep single-bit synchroniser, async active-low reset.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_bit #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  // Stage 0 may go metastable; the remaining stages give it time to settle.
  (* async_reg = "true" *) logic [SYNC_STAGES-1:0] r_stage;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stage <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      r_stage <= {r_stage[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_stage[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pipe_sync.sv
//------------------------------------------------------------------------------
// Module  : pipe_sync
// Brief   : Three matched-latency synchronisers for pixel, weight and enable.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_sync
  import bnn_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  pipe_sync_if.slave   bus
);

  localparam bit c_DEPTH_OK = sync_depth_legal(SYNC_STAGES);

  logic [NUM_CH-1:0] w_async;
  logic [NUM_CH-1:0] w_sync;

  assign w_async[CH_P]  = bus.async_in_p;
  assign w_async[CH_W]  = bus.async_in_w;
  assign w_async[CH_EN] = bus.async_in_en;

  // Identical chains keep enable aligned with the data it qualifies.
  generate
    if (c_DEPTH_OK) begin : g_depth_ok
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chain
        sync_bit #(
          .SYNC_STAGES (SYNC_STAGES),
          .RESET_VALUE (RESET_VALUE)
        ) u_sync_bit (
          .clk     (clk),
          .reset_n (reset_n),
          .i_async (w_async[gi]),
          .o_sync  (w_sync[gi])
        );
      end
    end else begin : g_depth_clamped
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chain
        sync_bit #(
          .SYNC_STAGES (SYNC_STAGES_MIN),
          .RESET_VALUE (RESET_VALUE)
        ) u_sync_bit (
          .clk     (clk),
          .reset_n (reset_n),
          .i_async (w_async[gi]),
          .o_sync  (w_sync[gi])
        );
      end
    end
  endgenerate

  assign bus.sync_out_p  = w_sync[CH_P];
  assign bus.sync_out_w  = w_sync[CH_W];
  assign bus.sync_out_en = w_sync[CH_EN];

endmodule

`default_nettype wire

// File: tb/tb_pipe_sync.sv
//------------------------------------------------------------------------------
// Module  : tb_pipe_sync
// Brief   : Self-checking bench for pipe_sync (vector table + random vs model).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_sync;
  import bnn_pkg::*;

  localparam int S = SYNC_STAGES_DEFAULT;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  pipe_sync_if u_if ();

  pipe_sync #(
    .SYNC_STAGES (S),
    .RESET_VALUE (1'b0)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] w_out;
  assign w_out = {u_if.sync_out_p, u_if.sync_out_w, u_if.sync_out_en};

  // Reference: a level sampled at an edge emerges S-1 edges later.
  logic [2:0] hist[$];

  function automatic logic [2:0] model_out();
    return (hist.size() == S) ? hist[0] : 3'b000;
  endfunction

  task automatic drive(input logic [2:0] v);
    u_if.async_in_p  = v[2];
    u_if.async_in_w  = v[1];
    u_if.async_in_en = v[0];
  endtask

  task automatic tick();
    if (reset_n) hist.push_back({u_if.async_in_p, u_if.async_in_w, u_if.async_in_en});
    @(posedge clk);
    #1;
    if (hist.size() > S) hist.delete(0);
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got p,w,en=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    hist.delete();
    #1;
    check("reset_async", w_out, 3'b000);
  endtask

  typedef struct {
    logic [2:0] in;
    logic [2:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    drive(3'b000);

    // Expected values assume the default two-stage depth.
    tbl[0]  = '{3'b001, 3'b000};
    tbl[1]  = '{3'b001, 3'b001};
    tbl[2]  = '{3'b001, 3'b001};
    tbl[3]  = '{3'b111, 3'b001};
    tbl[4]  = '{3'b111, 3'b111};
    tbl[5]  = '{3'b000, 3'b111};
    tbl[6]  = '{3'b000, 3'b000};
    tbl[7]  = '{3'b110, 3'b000};
    tbl[8]  = '{3'b110, 3'b110};
    tbl[9]  = '{3'b101, 3'b110};
    tbl[10] = '{3'b101, 3'b101};
    tbl[11] = '{3'b010, 3'b101};
    tbl[12] = '{3'b101, 3'b010};
    tbl[13] = '{3'b000, 3'b101};
    tbl[14] = '{3'b000, 3'b000};

    repeat (3) tick();
    check("reset_hold", w_out, 3'b000);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].in);
      tick();
      check($sformatf("table[%0d]", i), w_out, tbl[i].exp);
      check($sformatf("table_model[%0d]", i), w_out, model_out());
    end

    // Reset with all inputs high: clears without a clock and holds.
    drive(3'b111);
    repeat (5) tick();
    check("pre_reset_high", w_out, 3'b111);
    #2;
    assert_reset();
    tick();
    check("reset_edge", w_out, 3'b000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_held", w_out, 3'b000);
    end
    reset_n = 1'b1;
    tick();
    check("release_e1", w_out, 3'b000);
    tick();
    check("release_e2", w_out, 3'b111);
    repeat (2) tick();
    check("release_e4", w_out, 3'b111);

    // Data leading enable by two cycles.
    drive(3'b000);
    repeat (4) tick();
    drive(3'b110);
    repeat (2) tick();
    drive(3'b111);
    repeat (5) tick();
    check("data_leads_en", w_out, 3'b111);

    // Enable pulse held three cycles with p=1, w=0.
    drive(3'b101);
    repeat (3) tick();
    check("pulse_on", w_out, 3'b101);
    drive(3'b100);
    tick();
    check("pulse_tail", w_out, 3'b101);
    tick();
    check("pulse_off", w_out, 3'b100);

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        #($urandom_range(1, 3));
        assert_reset();
        drive(3'($urandom));
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          tick();
          check("rand_reset", w_out, 3'b000);
        end
        reset_n = 1'b1;
      end
      drive(3'($urandom));
      tick();
      check("rand_model", w_out, model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
